cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
- Shares a single cordic_top instance between two independent requesters (ch0, ch1) using round-robin arbitration.
- Accepts operand bundles over valid/ready channels and sequences the CORDIC start/done protocol.
- Returns results on a shared response channel tagged with the requester id.
- Includes a done-timeout watchdog so a hung datapath cannot deadlock the requesters.

Parameters:
- TIMEOUT_CYC, 64, max cycles in WAIT before aborting (min 2).
- DEF_NITER, 15, iteration count substituted when a request carries n_iter=0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  ch0 request valid
- req0_ready  out  1  ch0 request accepted this cycle
- req0_x, req0_y, req0_z  in  18 each  ch0 operands, signed Q2.16
- req0_mode  in  1  ch0 mode: 0 = rotation, 1 = vectoring
- req0_niter  in  4  ch0 iteration count
- req1_valid, req1_ready, req1_x, req1_y, req1_z, req1_mode, req1_niter  same as ch0, for ch1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_timeout  out  1  result aborted by watchdog
- rsp_xn, rsp_yn  out  19 each  result x/y
- rsp_zn  out  18  result z
- cq_start  out  1  one-cycle start pulse to CORDIC
- cq_x0, cq_y0, cq_z0  out  18 each  operands to CORDIC
- cq_rot0_vec1  out  1  mode to CORDIC
- cq_n_iter  out  4  iteration count to CORDIC
- cq_done  in  1  CORDIC done pulse
- cq_busy  in  1  CORDIC busy
- cq_xn, cq_yn  in  19 each  CORDIC x/y results
- cq_zn  in  18  CORDIC z result

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all outputs 0; last_grant = 1, so ch0 wins the first tie.
  - Operand and result registers = 0; timeout counter = 0.
  - rst asserted mid-operation: abandon the transaction, drop any pending response, no cq_start. A cq_done arriving after reset is ignored (state IDLE).
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - grant = the sole valid channel. If both are valid, grant = !last_grant.
  - reqK_ready = (state==IDLE) & reqK_valid & (grant==K). This is a single-cycle accept; at most one ready is high per cycle.
  - On accept: latch x/y/z/mode/niter into cq_* registers (niter 0 -> DEF_NITER), latch id, set last_grant = id, go to LAUNCH.
- LAUNCH:
  - If cq_busy = 0: assert cq_start for exactly one cycle, clear the counter, go to WAIT.
  - If cq_busy = 1: hold in LAUNCH with cq_start = 0.
- WAIT:
  - Counter increments each cycle; cq_* operands stay stable throughout.
  - cq_done = 1: capture cq_xn/yn/zn, set rsp_timeout = 0, go to RESP. cq_done takes priority over a simultaneous timeout.
  - Counter == TIMEOUT_CYC-1 without done: results = 0, set rsp_timeout = 1, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_timeout and rsp_x/y/zn are registered and stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. The next accept happens no earlier than the following cycle, so there is no back-to-back overlap.
  - cq_done pulses seen outside WAIT are ignored.
- Latency:
  - Accept at cycle T, cq_start at T+1 (when not busy).
  - If CORDIC asserts done at T+1+L, rsp_valid rises at T+2+L.
  - Throughput: one transaction in flight.
- Fairness: with both channels continuously valid, grants strictly alternate 0,1,0,1...
- Widths: operands pass through unchanged; no sign extension or saturation in this block.

Test Plan:
- Single ch0 rotation: x=32768, y=0, z=8192, mode=0, niter=15 -> req0_ready at T, cq_start at T+1 with identical operands; after done, rsp_valid with rsp_id=0, rsp_timeout=0 and rsp_* equal to cq_* results.
- Both channels valid from reset, 4 requests each (ch1 vectoring x=-39322, y=-52429) -> grant order 0,1,0,1,0,1,0,1; each rsp_id matches the issuing channel's operands.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_* stable, no req_ready, no cq_start; release -> IDLE next cycle.
- Stub CORDIC that never returns done, TIMEOUT_CYC=64 -> rsp_valid 64 cycles after cq_start, rsp_timeout=1, results 0; a following request proceeds normally.
- cq_busy held high 5 cycles after accept, and niter=0 -> cq_start delayed until busy falls; cq_n_iter=15.
- rst pulsed during WAIT, then stray cq_done -> no rsp_valid, all outputs 0, next request accepted normally.

Source files
------------

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
// Shares one CORDIC core between two requesters (ch0, ch1) with round-robin
// arbitration. Each request carries x/y/z operands, a mode bit and an
// iteration count. The arbiter launches the core, waits for its done pulse,
// and returns the result on a shared response channel tagged with the owner
// id. A watchdog aborts a transaction whose done pulse never arrives.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req{0,1}_valid/_ready     request handshake per channel
//   req{0,1}_x/_y/_z          18-bit signed Q2.16 operands
//   req{0,1}_mode             0 = rotation, 1 = vectoring
//   req{0,1}_niter            iteration count (0 selects DEF_NITER)
//   rsp_valid/_ready          response handshake
//   rsp_id                    requester owning the response
//   rsp_timeout               response produced by the watchdog
//   rsp_xn/_yn/_zn            result values
//   cq_start                  one-cycle start pulse to the CORDIC core
//   cq_x0/_y0/_z0, cq_rot0_vec1, cq_n_iter   operands to the core
//   cq_done, cq_busy          core status
//   cq_xn/_yn/_zn             core results
module cordic_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [3:0]  DEF_NITER   = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [17:0] req0_x,
  input  logic [17:0] req0_y,
  input  logic [17:0] req0_z,
  input  logic        req0_mode,
  input  logic [3:0]  req0_niter,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [17:0] req1_x,
  input  logic [17:0] req1_y,
  input  logic [17:0] req1_z,
  input  logic        req1_mode,
  input  logic [3:0]  req1_niter,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_timeout,
  output logic [18:0] rsp_xn,
  output logic [18:0] rsp_yn,
  output logic [17:0] rsp_zn,
  output logic        cq_start,
  output logic [17:0] cq_x0,
  output logic [17:0] cq_y0,
  output logic [17:0] cq_z0,
  output logic        cq_rot0_vec1,
  output logic [3:0]  cq_n_iter,
  input  logic        cq_done,
  input  logic        cq_busy,
  input  logic [18:0] cq_xn,
  input  logic [18:0] cq_yn,
  input  logic [17:0] cq_zn
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic          last_grant;
  logic          cur_id;
  logic          grant;
  logic          accept;
  logic          expired;
  logic [CW-1:0] cnt;

  logic [17:0]   sel_x;
  logic [17:0]   sel_y;
  logic [17:0]   sel_z;
  logic          sel_mode;
  logic [3:0]    sel_niter;

  // Round-robin: a tie goes to the channel that was not granted last.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end
  end

  always_comb begin
    sel_x     = req0_x;
    sel_y     = req0_y;
    sel_z     = req0_z;
    sel_mode  = req0_mode;
    sel_niter = req0_niter;
    if (grant) begin
      sel_x     = req1_x;
      sel_y     = req1_y;
      sel_z     = req1_z;
      sel_mode  = req1_mode;
      sel_niter = req1_niter;
    end
  end

  // Ready and start are handshake strobes for the current cycle, so they are
  // decoded from the registered state; reset forces them low.
  assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~grant;
  assign req1_ready = ~rst & (state == IDLE) & req1_valid &  grant;
  assign accept     = req0_ready | req1_ready;
  assign cq_start   = ~rst & (state == LAUNCH) & ~cq_busy;

  // cnt is cleared on the start pulse and advances on every WAIT cycle, so
  // cnt+1 is the number of cycles elapsed since the start pulse; the abort
  // fires on the cycle that reaches TIMEOUT_CYC-1 elapsed.
  assign expired = (cnt + CW'(1)) == CW'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      cnt          <= '0;
      cq_x0        <= '0;
      cq_y0        <= '0;
      cq_z0        <= '0;
      cq_rot0_vec1 <= 1'b0;
      cq_n_iter    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_timeout  <= 1'b0;
      rsp_xn       <= '0;
      rsp_yn       <= '0;
      rsp_zn       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cq_x0        <= sel_x;
            cq_y0        <= sel_y;
            cq_z0        <= sel_z;
            cq_rot0_vec1 <= sel_mode;
            cq_n_iter    <= (sel_niter == 4'd0) ? DEF_NITER : sel_niter;
            cur_id       <= grant;
            last_grant   <= grant;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!cq_busy) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (cq_done) begin
            rsp_xn      <= cq_xn;
            rsp_yn      <= cq_yn;
            rsp_zn      <= cq_zn;
            rsp_timeout <= 1'b0;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (expired) begin
            rsp_xn      <= '0;
            rsp_yn      <= '0;
            rsp_zn      <= '0;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter. The bench plays the CORDIC core
// itself (start -> done after a chosen latency, with bench-chosen results)
// and keeps a request-queue model of the two requesters plus a round-robin
// grant predictor.
module tb_cordic_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv [2];
  logic        rdy [2];
  logic [17:0] rx [2];
  logic [17:0] ry [2];
  logic [17:0] rz [2];
  logic        rm [2];
  logic [3:0]  rn [2];
  logic        rsp_valid, rsp_ready, rsp_id, rsp_timeout;
  logic [18:0] rsp_xn, rsp_yn;
  logic [17:0] rsp_zn;
  logic        cq_start, cq_rot0_vec1, cq_done, cq_busy;
  logic [17:0] cq_x0, cq_y0, cq_z0;
  logic [3:0]  cq_n_iter;
  logic [18:0] cq_xn, cq_yn;
  logic [17:0] cq_zn;

  cordic_arbiter #(.TIMEOUT_CYC(64), .DEF_NITER(4'd15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_x(rx[0]), .req0_y(ry[0]),
    .req0_z(rz[0]), .req0_mode(rm[0]), .req0_niter(rn[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_x(rx[1]), .req1_y(ry[1]),
    .req1_z(rz[1]), .req1_mode(rm[1]), .req1_niter(rn[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_timeout(rsp_timeout), .rsp_xn(rsp_xn), .rsp_yn(rsp_yn), .rsp_zn(rsp_zn),
    .cq_start(cq_start), .cq_x0(cq_x0), .cq_y0(cq_y0), .cq_z0(cq_z0),
    .cq_rot0_vec1(cq_rot0_vec1), .cq_n_iter(cq_n_iter), .cq_done(cq_done),
    .cq_busy(cq_busy), .cq_xn(cq_xn), .cq_yn(cq_yn), .cq_zn(cq_zn)
  );

  typedef struct {
    logic [17:0] x, y, z;
    logic        m;
    logic [3:0]  n;
  } req_t;

  typedef struct {
    bit acc; int acc_id; int acc_cyc; int nacc; bit dual;
    bit started; int start_cyc; int nstart;
    logic [17:0] cx, cy, cz; logic cm; logic [3:0] cn;
    bit got; int rsp_cyc; int hs_cyc;
    logic rid, rto; logic [18:0] rxn, ryn; logic [17:0] rzn;
    logic [18:0] exn, eyn; logic [17:0] ezn;
    bit unstable; bit spur;
  } obs_t;

  req_t q0[$];
  req_t q1[$];
  int   m_last;
  int   cycle = 0;
  int   npass = 0;
  int   ntot  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] eff_niter(input logic [3:0] n);
    return (n == 4'd0) ? 4'd15 : n;
  endfunction

  function automatic req_t rnd_req(input bit ch);
    req_t r;
    r.z = 18'($urandom);
    r.n = 4'($urandom_range(0, 15));
    if (ch) begin
      r.x = 18'(-39322);
      r.y = 18'(-52429);
      r.m = 1'b1;
    end else begin
      r.x = 18'($urandom);
      r.y = 18'($urandom);
      r.m = 1'b0;
    end
    return r;
  endfunction

  // Round-robin predictor: alternate on contention, otherwise the sole requester.
  function automatic int model_grant();
    if (q0.size() > 0 && q1.size() > 0) return (m_last == 0) ? 1 : 0;
    return (q1.size() > 0) ? 1 : 0;
  endfunction

  function automatic req_t front(input int ch);
    return (ch == 1) ? q1[0] : q0[0];
  endfunction

  task automatic present();
    rv[0] = q0.size() > 0;
    rv[1] = q1.size() > 0;
    if (rv[0]) begin rx[0] = q0[0].x; ry[0] = q0[0].y; rz[0] = q0[0].z; rm[0] = q0[0].m; rn[0] = q0[0].n; end
    if (rv[1]) begin rx[1] = q1[0].x; ry[1] = q1[0].y; rz[1] = q1[0].z; rm[1] = q1[0].m; rn[1] = q1[0].n; end
  endtask

  // Runs one transaction end to end, acting as the CORDIC core, and records
  // what the DUT did. No comparisons here; the test tasks judge the record.
  task automatic serve(input int lat, input bit never, input int busy, input int bp, output obs_t o);
    int n, held, done_at, bl;
    bit seen;
    o.acc = 0; o.acc_id = 0; o.acc_cyc = 0; o.nacc = 0; o.dual = 0;
    o.started = 0; o.start_cyc = 0; o.nstart = 0; o.got = 0; o.rsp_cyc = 0; o.hs_cyc = 0;
    o.unstable = 0; o.spur = 0;
    o.cx = '0; o.cy = '0; o.cz = '0; o.cm = 0; o.cn = '0;
    o.rid = 0; o.rto = 0; o.rxn = '0; o.ryn = '0; o.rzn = '0;
    o.exn = 19'($urandom); o.eyn = 19'($urandom); o.ezn = 18'($urandom);
    n = 0; held = 0; done_at = -1; bl = busy; seen = 0;
    while (!o.got && n < 400) begin
      present();
      cq_busy = o.acc && !o.started && bl > 0;
      if (cq_busy) bl--;
      cq_xn = 19'($urandom); cq_yn = 19'($urandom); cq_zn = 18'($urandom);
      cq_done = 1'b0;
      if (o.started && !never && cycle == done_at) begin
        cq_done = 1'b1; cq_xn = o.exn; cq_yn = o.eyn; cq_zn = o.ezn;
      end else if (bp > 0 && seen) begin
        cq_done = 1'b1;  // stray done while the response is pending
      end
      rsp_ready = (rsp_valid === 1'b1) && (held >= bp);
      #1;
      if (rdy[0] === 1'b1 || rdy[1] === 1'b1) begin
        o.nacc++;
        if (!o.acc) begin
          o.acc = 1; o.acc_cyc = cycle; o.acc_id = (rdy[1] === 1'b1) ? 1 : 0;
          o.dual = (rdy[0] === 1'b1) && (rdy[1] === 1'b1);
        end
        if (rdy[0] === 1'b1) void'(q0.pop_front());
        if (rdy[1] === 1'b1) void'(q1.pop_front());
      end
      if (cq_start === 1'b1) begin
        o.nstart++;
        if (!o.started) begin
          o.started = 1; o.start_cyc = cycle; done_at = cycle + lat;
          o.cx = cq_x0; o.cy = cq_y0; o.cz = cq_z0; o.cm = cq_rot0_vec1; o.cn = cq_n_iter;
        end
      end
      if (rsp_valid === 1'b1) begin
        if (!seen) begin
          seen = 1; o.rsp_cyc = cycle;
          o.rid = rsp_id; o.rto = rsp_timeout; o.rxn = rsp_xn; o.ryn = rsp_yn; o.rzn = rsp_zn;
        end else if ({rsp_id, rsp_timeout, rsp_xn, rsp_yn, rsp_zn} !== {o.rid, o.rto, o.rxn, o.ryn, o.rzn}) begin
          o.unstable = 1;
        end
        if (!rsp_ready && (rdy[0] === 1'b1 || rdy[1] === 1'b1 || cq_start === 1'b1)) o.spur = 1;
        held++;
        if (rsp_ready) begin o.got = 1; o.hs_cyc = cycle; end
      end
      cyc();
      n++;
    end
    cq_done = 1'b0; cq_busy = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rv[0] = 1'b1; rv[1] = 1'b1;
    cyc(); cyc();
    #1;
    ntot++; if ({rdy[0], rdy[1], cq_start} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {rdy[0], rdy[1], cq_start}); else npass++;
    rv[0] = 1'b0; rv[1] = 1'b0;
    rst = 1'b0;
    cyc();
    ntot++; if ({rsp_valid, rsp_id, rsp_timeout, rsp_xn, rsp_yn, rsp_zn} !== '0)
      $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_timeout, rsp_xn, rsp_yn, rsp_zn}); else npass++;
    ntot++; if ({cq_x0, cq_y0, cq_z0, cq_rot0_vec1, cq_n_iter} !== '0)
      $display("FAIL reset_cq: got %h want 0", {cq_x0, cq_y0, cq_z0, cq_rot0_vec1, cq_n_iter}); else npass++;
    m_last = 1;
  endtask

  task automatic test_fairness();
    obs_t o;
    req_t e;
    int exp_id, lat;
    for (int i = 0; i < 4; i++) begin q0.push_back(rnd_req(0)); q1.push_back(rnd_req(1)); end
    for (int i = 0; i < 8; i++) begin
      exp_id = model_grant();
      e = front(exp_id);
      lat = $urandom_range(1, 20);
      serve(lat, 0, 0, 0, o);
      m_last = exp_id;
      ntot++; if (!o.got) $display("FAIL fair_done[%0d]: no response within bound", i); else npass++;
      ntot++; if (o.acc_id != exp_id || o.dual || o.nacc != 1)
        $display("FAIL fair_grant[%0d]: got id %0d dual %0d accepts %0d want id %0d single accept", i, o.acc_id, o.dual, o.nacc, exp_id); else npass++;
      ntot++; if ({o.cx, o.cy, o.cz, o.cm, o.cn} !== {e.x, e.y, e.z, e.m, eff_niter(e.n)})
        $display("FAIL fair_ops[%0d]: got %h want %h", i, {o.cx, o.cy, o.cz, o.cm, o.cn}, {e.x, e.y, e.z, e.m, eff_niter(e.n)}); else npass++;
      ntot++; if ({o.rid, o.rto, o.rxn, o.ryn, o.rzn} !== {exp_id[0], 1'b0, o.exn, o.eyn, o.ezn})
        $display("FAIL fair_rsp[%0d]: got %h want %h", i, {o.rid, o.rto, o.rxn, o.ryn, o.rzn}, {exp_id[0], 1'b0, o.exn, o.eyn, o.ezn}); else npass++;
      ntot++; if (o.rsp_cyc - o.acc_cyc != lat + 2)
        $display("FAIL fair_latency[%0d]: got %0d want %0d", i, o.rsp_cyc - o.acc_cyc, lat + 2); else npass++;
    end
  endtask

  task automatic test_single_ch0();
    obs_t o;
    req_t r;
    int lat;
    r.x = 18'd32768; r.y = 18'd0; r.z = 18'd8192; r.m = 1'b0; r.n = 4'd15;
    q0.push_back(r);
    lat = $urandom_range(3, 20);
    serve(lat, 0, 0, 0, o);
    m_last = 0;
    ntot++; if (!o.got || o.acc_id != 0) $display("FAIL single_accept: got done %0d id %0d want 1 0", o.got, o.acc_id); else npass++;
    ntot++; if (o.start_cyc != o.acc_cyc + 1 || o.nstart != 1)
      $display("FAIL single_start: got offset %0d pulses %0d want 1 1", o.start_cyc - o.acc_cyc, o.nstart); else npass++;
    ntot++; if ({o.cx, o.cy, o.cz, o.cm, o.cn} !== {18'd32768, 18'd0, 18'd8192, 1'b0, 4'd15})
      $display("FAIL single_ops: got %h want %h", {o.cx, o.cy, o.cz, o.cm, o.cn}, {18'd32768, 18'd0, 18'd8192, 1'b0, 4'd15}); else npass++;
    ntot++; if (o.rsp_cyc != o.start_cyc + lat + 1)
      $display("FAIL single_rsp_time: got %0d want %0d", o.rsp_cyc - o.start_cyc, lat + 1); else npass++;
    ntot++; if ({o.rid, o.rto, o.rxn, o.ryn, o.rzn} !== {1'b0, 1'b0, o.exn, o.eyn, o.ezn})
      $display("FAIL single_rsp: got %h want %h", {o.rid, o.rto, o.rxn, o.ryn, o.rzn}, {1'b0, 1'b0, o.exn, o.eyn, o.ezn}); else npass++;
  endtask

  task automatic test_backpressure();
    obs_t o, o2;
    int exp_id;
    q0.push_back(rnd_req(0));
    q1.push_back(rnd_req(1));
    exp_id = model_grant();
    serve($urandom_range(1, 10), 0, 0, 10, o);
    m_last = exp_id;
    ntot++; if (!o.got || o.acc_id != exp_id) $display("FAIL bp_accept: got done %0d id %0d want 1 %0d", o.got, o.acc_id, exp_id); else npass++;
    ntot++; if (o.unstable || o.spur) $display("FAIL bp_hold: got unstable %0d spurious %0d want 0 0", o.unstable, o.spur); else npass++;
    ntot++; if (o.hs_cyc != o.rsp_cyc + 10) $display("FAIL bp_hold_len: got %0d want 10", o.hs_cyc - o.rsp_cyc); else npass++;
    ntot++; if ({o.rid, o.rxn, o.ryn, o.rzn} !== {exp_id[0], o.exn, o.eyn, o.ezn})
      $display("FAIL bp_rsp: got %h want %h", {o.rid, o.rxn, o.ryn, o.rzn}, {exp_id[0], o.exn, o.eyn, o.ezn}); else npass++;
    exp_id = model_grant();
    serve($urandom_range(1, 10), 0, 0, 0, o2);
    m_last = exp_id;
    ntot++; if (o2.acc_cyc != o.hs_cyc + 1 || o2.acc_id != exp_id)
      $display("FAIL bp_next_accept: got offset %0d id %0d want 1 %0d", o2.acc_cyc - o.hs_cyc, o2.acc_id, exp_id); else npass++;
  endtask

  task automatic test_busy_niter0();
    obs_t o;
    req_t r;
    r = rnd_req(1);
    r.n = 4'd0;
    q1.push_back(r);
    serve($urandom_range(1, 8), 0, 5, 0, o);
    m_last = 1;
    ntot++; if (o.start_cyc != o.acc_cyc + 6 || o.nstart != 1)
      $display("FAIL busy_start: got offset %0d pulses %0d want 6 1", o.start_cyc - o.acc_cyc, o.nstart); else npass++;
    ntot++; if (o.cn !== 4'd15) $display("FAIL niter_default: got %0d want 15", o.cn); else npass++;
    ntot++; if (!o.got || o.rid !== 1'b1 || o.rxn !== o.exn)
      $display("FAIL busy_rsp: got done %0d id %0d xn %h want 1 1 %h", o.got, o.rid, o.rxn, o.exn); else npass++;
  endtask

  task automatic test_timeout();
    obs_t o;
    q0.push_back(rnd_req(0));
    serve(0, 1, 0, 0, o);
    m_last = 0;
    ntot++; if (!o.got || o.rsp_cyc != o.start_cyc + 64)
      $display("FAIL timeout_time: got done %0d offset %0d want 1 64", o.got, o.rsp_cyc - o.start_cyc); else npass++;
    ntot++; if ({o.rto, o.rxn, o.ryn, o.rzn} !== {1'b1, 56'd0})
      $display("FAIL timeout_rsp: got %h want %h", {o.rto, o.rxn, o.ryn, o.rzn}, {1'b1, 56'd0}); else npass++;
    // Done on the last cycle before the abort wins over the watchdog.
    q1.push_back(rnd_req(1));
    serve(63, 0, 0, 0, o);
    m_last = 1;
    ntot++; if (!o.got || o.rsp_cyc != o.start_cyc + 64 || {o.rto, o.rxn} !== {1'b0, o.exn})
      $display("FAIL done_vs_timeout: got offset %0d to %0d xn %h want 64 0 %h", o.rsp_cyc - o.start_cyc, o.rto, o.rxn, o.exn); else npass++;
    q0.push_back(rnd_req(0));
    serve(5, 0, 0, 0, o);
    m_last = 0;
    ntot++; if (!o.got || {o.rid, o.rto, o.rxn, o.ryn, o.rzn} !== {1'b0, 1'b0, o.exn, o.eyn, o.ezn})
      $display("FAIL after_timeout: got %h want %h", {o.rid, o.rto, o.rxn, o.ryn, o.rzn}, {1'b0, 1'b0, o.exn, o.eyn, o.ezn}); else npass++;
  endtask

  task automatic test_reset_midwait();
    obs_t o;
    int n, exp_id;
    bit started, viol;
    q0.push_back(rnd_req(0));
    started = 0; n = 0; rsp_ready = 1'b0;
    while (!started && n < 50) begin
      present(); #1;
      if (rdy[0] === 1'b1) void'(q0.pop_front());
      if (rdy[1] === 1'b1) void'(q1.pop_front());
      if (cq_start === 1'b1) started = 1;
      cyc(); n++;
    end
    ntot++; if (!started) $display("FAIL midrst_launch: got no start within %0d cycles want start", n); else npass++;
    repeat (3) begin present(); cyc(); end
    rst = 1'b1; present(); cyc(); rst = 1'b0;
    cq_done = 1'b1; cq_xn = 19'($urandom); cq_yn = 19'($urandom); cq_zn = 18'($urandom);
    present(); cyc(); cq_done = 1'b0;
    viol = 0;
    repeat (6) begin
      present(); #1;
      if (rsp_valid !== 1'b0 || cq_start !== 1'b0 || rdy[0] !== 1'b0 || rdy[1] !== 1'b0) viol = 1;
      cyc();
    end
    ntot++; if (viol) $display("FAIL midrst_quiet: got activity after reset want none"); else npass++;
    ntot++; if ({rsp_valid, rsp_id, rsp_timeout, rsp_xn, rsp_yn, rsp_zn, cq_x0, cq_y0, cq_z0, cq_rot0_vec1, cq_n_iter} !== '0)
      $display("FAIL midrst_outputs: got %h want 0", {rsp_valid, rsp_id, rsp_timeout, rsp_xn, rsp_yn, rsp_zn, cq_x0, cq_y0, cq_z0, cq_rot0_vec1, cq_n_iter}); else npass++;
    m_last = 1;
    q0.push_back(rnd_req(0));
    q1.push_back(rnd_req(1));
    exp_id = model_grant();
    serve(4, 0, 0, 0, o);
    m_last = exp_id;
    ntot++; if (!o.got || o.acc_id != exp_id || {o.rid, o.rto, o.rxn} !== {exp_id[0], 1'b0, o.exn})
      $display("FAIL midrst_next: got done %0d id %0d rsp %h want 1 %0d %h", o.got, o.acc_id, {o.rid, o.rto, o.rxn}, exp_id, {exp_id[0], 1'b0, o.exn}); else npass++;
    exp_id = model_grant();
    serve(4, 0, 0, 0, o);
    m_last = exp_id;
    ntot++; if (!o.got || o.acc_id != exp_id) $display("FAIL midrst_drain: got done %0d id %0d want 1 %0d", o.got, o.acc_id, exp_id); else npass++;
  endtask

  initial begin
    rst = 1'b1;
    rv[0] = 1'b0; rv[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin rx[i] = '0; ry[i] = '0; rz[i] = '0; rm[i] = 1'b0; rn[i] = '0; end
    rsp_ready = 1'b0; cq_done = 1'b0; cq_busy = 1'b0;
    cq_xn = '0; cq_yn = '0; cq_zn = '0;
    m_last = 1;
    cyc();
    test_reset();
    test_fairness();
    test_single_ch0();
    test_backpressure();
    test_busy_niter0();
    test_timeout();
    test_reset_midwait();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
